// File: rtl/pipe_hazard_scoreboard.sv
// Hazard and forwarding unit for the WISC pipeline.
// Keeps a shadow copy of the destination registers in flight after decode.
// From it the unit derives the operand forwarding selects, the load-use
// stall and a busy mask of pending writes.
module pipe_hazard_scoreboard #(
    parameter int NUM_REGS      = 16,
    parameter int REG_W         = 4,
    parameter int STAGES        = 3,
    parameter int LOAD_USE_DIST = 1,
    parameter int FSEL_W        = 2,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic                issue_wr,
    input  logic                issue_is_load,
    input  logic [REG_W-1:0]    issue_rd,
    input  logic [REG_W-1:0]    src_rs,
    input  logic [REG_W-1:0]    src_rt,
    input  logic                src_rs_used,
    input  logic                src_rt_used,
    input  logic                flush,
    output logic                stall,
    output logic [FSEL_W-1:0]   fwd_sel_rs,
    output logic [FSEL_W-1:0]   fwd_sel_rt,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [CNT_W-1:0]    stall_count
);

    // Shadow pipeline. Index 0 is EX and index STAGES-1 is the last write-back stage.
    // Only the valid bits are reset. The payload is meaningless while its valid bit is low.
    logic             ent_vld [STAGES];
    logic             ent_wr  [STAGES];
    logic             ent_ld  [STAGES];
    logic [REG_W-1:0] ent_rd  [STAGES];

    logic             blk_rs;
    logic             blk_rt;
    logic             enter_p0;

    // Saturating increment for the stall counter. It holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // An entry produces a source when it is a live write to that non-zero register,
    // and only when the operand is actually read.
    function automatic logic src_match(input logic             vld,
                                       input logic             wr,
                                       input logic [REG_W-1:0] rd,
                                       input logic [REG_W-1:0] s,
                                       input logic             used);
        return vld && wr && (rd == s) && (s != '0) && used;
    endfunction

    // Youngest-producer search for each operand.
    // Walking from oldest to youngest lets the youngest match overwrite the others.
    // The youngest match alone decides both the select and whether a load blocks.
    always_comb begin
        fwd_sel_rs = '0;
        fwd_sel_rt = '0;
        blk_rs     = 1'b0;
        blk_rt     = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (src_match(ent_vld[i], ent_wr[i], ent_rd[i], src_rs, src_rs_used)) begin
                fwd_sel_rs = FSEL_W'(i + 1);
                blk_rs     = ent_ld[i] && (i < LOAD_USE_DIST);
            end
            if (src_match(ent_vld[i], ent_wr[i], ent_rd[i], src_rt, src_rt_used)) begin
                fwd_sel_rt = FSEL_W'(i + 1);
                blk_rt     = ent_ld[i] && (i < LOAD_USE_DIST);
            end
        end
    end

    // A flush kills the ID instruction, so it also overrides any load-use stall.
    always_comb begin
        stall    = !flush && issue_valid && (blk_rs || blk_rt);
        enter_p0 = issue_valid && !stall && !flush;
    end

    // Pending-write mask. R0 is never reported.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (ent_vld[i] && ent_wr[i] && (ent_rd[i] != '0)) begin
                busy_mask[ent_rd[i]] = 1'b1;
            end
        end
    end

    // Valid bits shift every cycle, because downstream stages never stall.
    // A flush squashes EX on its way into the next stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                ent_vld[i] <= 1'b0;
            end
        end else begin
            ent_vld[0] <= enter_p0;
            for (int i = 1; i < STAGES; i++) begin
                ent_vld[i] <= (i == 1) ? (ent_vld[0] && !flush) : ent_vld[i-1];
            end
        end
    end

    // Payload shift. The payload of a bubble is don't-care.
    always_ff @(posedge clk) begin
        ent_wr[0] <= issue_wr;
        ent_ld[0] <= issue_is_load;
        ent_rd[0] <= issue_rd;
        for (int i = 1; i < STAGES; i++) begin
            ent_wr[i] <= ent_wr[i-1];
            ent_ld[i] <= ent_ld[i-1];
            ent_rd[i] <= ent_rd[i-1];
        end
    end

    // Performance counter of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall) begin
            stall_count <= sat_inc(stall_count);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed plus randomized bench for pipe_hazard_scoreboard.
// The reference keeps a queue of in-flight instructions, youngest first.
module tb_pipe_hazard_scoreboard;

    localparam int ST   = 3;
    localparam int LUD  = 1;
    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_wr, issue_is_load;
    logic [3:0]  issue_rd, src_rs, src_rt;
    logic        src_rs_used, src_rt_used, flush;
    logic        stall;
    logic [1:0]  fwd_sel_rs, fwd_sel_rt;
    logic [15:0] busy_mask;
    logic [CW-1:0] stall_count;

    pipe_hazard_scoreboard #(
        .NUM_REGS(16), .REG_W(4), .STAGES(ST), .LOAD_USE_DIST(LUD),
        .FSEL_W(2), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_is_load(issue_is_load),
        .issue_rd(issue_rd), .src_rs(src_rs), .src_rt(src_rt),
        .src_rs_used(src_rs_used), .src_rt_used(src_rt_used), .flush(flush),
        .stall(stall), .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt),
        .busy_mask(busy_mask), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       vld;
        bit       wr;
        bit       ld;
        bit [3:0] rd;
    } ent_t;

    ent_t q[$];
    int   ref_cnt;
    int   tests = 0;
    int   fails = 0;

    // values observed in the most recent step
    logic        o_stall;
    logic [1:0]  o_rs, o_rt;
    logic [15:0] o_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Position+1 of the youngest in-flight writer of s, or 0.
    function automatic int ref_pos(input bit [3:0] s, input bit used);
        for (int k = 0; k < q.size(); k++)
            if (used && s != 0 && q[k].vld && q[k].wr && q[k].rd == s) return k + 1;
        return 0;
    endfunction

    function automatic bit ref_blocks(input bit [3:0] s, input bit used);
        int p = ref_pos(s, used);
        return (p != 0) && q[p-1].ld && (p - 1 < LUD);
    endfunction

    function automatic logic [15:0] ref_busy();
        logic [15:0] m = '0;
        foreach (q[k]) if (q[k].vld && q[k].wr && q[k].rd != 0) m[q[k].rd] = 1'b1;
        return m;
    endfunction

    // Applies one ID cycle, checks the combinational outputs, clocks it and checks the counter.
    task automatic step(input bit v, input bit wr, input bit ld, input bit [3:0] rd,
                        input bit [3:0] rs, input bit rsu, input bit [3:0] rt, input bit rtu,
                        input bit fl);
        bit   e_stall;
        ent_t n;
        issue_valid = v; issue_wr = wr; issue_is_load = ld; issue_rd = rd;
        src_rs = rs; src_rs_used = rsu; src_rt = rt; src_rt_used = rtu; flush = fl;
        #2;
        e_stall = v && !fl && (ref_blocks(rs, rsu) || ref_blocks(rt, rtu));
        o_stall = stall; o_rs = fwd_sel_rs; o_rt = fwd_sel_rt; o_busy = busy_mask;
        chk("stall", stall, e_stall);
        chk("fwd_sel_rs", fwd_sel_rs, ref_pos(rs, rsu));
        chk("fwd_sel_rt", fwd_sel_rt, ref_pos(rt, rtu));
        chk("busy_mask", busy_mask, ref_busy());
        @(posedge clk);
        #1;
        if (fl && q.size() > 0) q[0].vld = 0;
        n.vld = v && !e_stall && !fl; n.wr = wr; n.ld = ld; n.rd = rd;
        q.push_front(n);
        while (q.size() > ST) void'(q.pop_back());
        if (e_stall && ref_cnt < MAXC) ref_cnt++;
        chk("stall_count", stall_count, ref_cnt);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Drops reset between clock edges and checks that the outputs clear at once.
    task automatic reset_mid(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_fsel_rs"}, fwd_sel_rs, 0);
        chk({tag, "_fsel_rt"}, fwd_sel_rt, 0);
        chk({tag, "_busy"}, busy_mask, 0);
        chk({tag, "_count"}, stall_count, 0);
        q.delete();
        ref_cnt = 0;
        issue_valid = 0; flush = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit       hold;
        bit       v, wr, ld, rsu, rtu, fl;
        bit [3:0] rd, rs, rt;
        rst_n = 1'b0;
        issue_valid = 0; issue_wr = 0; issue_is_load = 0; issue_rd = 0;
        src_rs = 0; src_rt = 0; src_rs_used = 0; src_rt_used = 0; flush = 0;
        ref_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("por_stall", stall, 0);
        chk("por_busy", busy_mask, 0);
        chk("por_count", stall_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back ALU forwarding ages out through every stage
        step(1, 1, 0, 3, 0, 0, 0, 0, 0);
        step(1, 1, 0, 6, 3, 1, 0, 0, 0);
        chk("alu_sel1", o_rs, 1); chk("alu_nostall", o_stall, 0);
        step(1, 0, 0, 0, 3, 1, 0, 0, 0);
        chk("alu_sel2", o_rs, 2);
        step(1, 0, 0, 0, 3, 1, 0, 0, 0);
        chk("alu_sel3", o_rs, 3);
        step(1, 0, 0, 0, 3, 1, 0, 0, 0);
        chk("alu_sel0", o_rs, 0);

        // load-use: exactly one stall cycle, then forward from MEM
        step(1, 1, 1, 5, 0, 0, 0, 0, 0);
        step(1, 1, 0, 7, 0, 0, 5, 1, 0);
        chk("lu_stall", o_stall, 1);
        step(1, 1, 0, 7, 0, 0, 5, 1, 0);
        chk("lu_release", o_stall, 0);
        chk("lu_sel_rt", o_rt, 2);
        chk("lu_count", stall_count, 1);

        // youngest producer decides
        step(1, 1, 0, 2, 0, 0, 0, 0, 0);
        step(1, 1, 1, 2, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 2, 1, 0, 0, 0);
        chk("yw_load_stall", o_stall, 1);
        step(1, 0, 0, 0, 2, 1, 0, 0, 0);
        step(1, 1, 1, 2, 0, 0, 0, 0, 0);
        step(1, 1, 0, 2, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 2, 1, 0, 0, 0);
        chk("yw_alu_nostall", o_stall, 0);
        chk("yw_alu_sel", o_rs, 1);

        // flush overrides the stall and squashes the load
        idle(); idle(); idle();
        step(1, 1, 1, 4, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 4, 1, 0, 0, 1);
        chk("fl_nostall", o_stall, 0);
        idle();
        chk("fl_busy4", o_busy[4], 0);
        chk("fl_count", stall_count, 2);

        // R0 is never tracked
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 1, 0, 1, 0);
        chk("r0_sel", o_rs, 0);
        chk("r0_busy", o_busy, 0);
        step(1, 0, 0, 0, 0, 1, 0, 1, 0);
        chk("r0_nostall", o_stall, 0);

        // mid-run reset with three loads in flight and a blocked reader in ID
        step(1, 1, 1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 2, 0, 0, 0, 0, 0);
        step(1, 1, 1, 3, 0, 0, 0, 0, 0);
        issue_valid = 1; issue_wr = 0; src_rs = 3; src_rs_used = 1; src_rt = 1; src_rt_used = 1;
        reset_mid("rst");

        // counter saturation after five stalls
        for (int n = 0; n < 5; n++) begin
            step(1, 1, 1, 7, 0, 0, 0, 0, 0);
            step(1, 0, 0, 0, 7, 1, 0, 0, 0);
            step(1, 0, 0, 0, 7, 1, 0, 0, 0);
        end
        chk("sat_count", stall_count, MAXC);

        // randomized traffic; a stalled instruction is held in ID
        hold = 0;
        v = 0; wr = 0; ld = 0; rd = 0; rs = 0; rt = 0; rsu = 0; rtu = 0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                v   = ($urandom_range(3) != 0);
                wr  = ($urandom_range(4) != 0);
                ld  = ($urandom_range(2) == 0);
                rd  = 4'($urandom_range(7));
                rs  = 4'($urandom_range(7));
                rt  = 4'($urandom_range(7));
                rsu = $urandom_range(1);
                rtu = $urandom_range(1);
            end
            fl = ($urandom_range(7) == 0);
            step(v, wr, ld, rd, rs, rsu, rt, rtu, fl);
            hold = o_stall;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
